// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: turns load-use, taken-branch,
// data-memory wait and halt causes into PC / IF/ID / ID/EX / EX/MEM controls.
module pipeline_hazard_sequencer #(
  parameter int MAX_MEM_WAIT = 15,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_hold,
  output logic [1:0]        seq_state,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

  state_t     state_q, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       timeout_set;
  logic       load_use;

  assign load_use = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign seq_state = state_q;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    state_nxt   = state_q;
    wait_nxt    = wait_cnt;
    timeout_set = 1'b0;

    case (state_q)
      RUN, LOAD_STALL, MEM_WAIT: begin
        if ((state_q == MEM_WAIT) && mem_busy) begin
          // Still waiting on memory; a pending halt is deferred until it drops.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
          if (wait_cnt < WAIT_LIMIT) begin
            wait_nxt = wait_cnt + 8'd1;
          end else begin
            timeout_set = 1'b1;
            wait_nxt    = 8'd0;
            state_nxt   = HALTED;
          end
        end else begin
          wait_nxt  = 8'd0;
          state_nxt = RUN;
          if (halt_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_nxt  = HALTED;
          end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            wait_nxt   = 8'd1;
            state_nxt  = MEM_WAIT;
          end else if (load_use && (state_q != LOAD_STALL)) begin
            // Holding ID also re-presents any taken branch next cycle, so no flush now.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = LOAD_STALL;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
      end
      default: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
        if (resume && !halt_req && !mem_timeout) begin
          state_nxt = RUN;
        end
      end
    endcase

    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write && (state_q != HALTED) && (stall_cycles != {PERF_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scenario bench for pipeline_hazard_sequencer: table-driven rows, expected
// control vectors queued at drive time and popped when the outputs settle.
module tb_pipeline_hazard_sequencer;

  localparam int PERF_W = 4;

  // Row layout: rs, rt, ex_rt, then {uses_rt, memread, br, busy, halt, res}.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] ex_rt;
    logic       uses_rt;
    logic       memread;
    logic       br;
    logic       busy;
    logic       halt;
    logic       res;
  } stim_t;

  localparam stim_t IDLE = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [4:0]        id_rs = '0, id_rt = '0, ex_rt = '0;
  logic              id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
  logic              mem_busy = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
  logic [1:0]        seq_state;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;

  // Observed vector: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, seq_state, mem_timeout
  logic [8:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, seq_state, mem_timeout};

  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  pipeline_hazard_sequencer #(.MAX_MEM_WAIT(4), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .seq_state(seq_state),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic drive_now(input stim_t s);
    id_rs        = s.rs;
    id_rt        = s.rt;
    ex_rt        = s.ex_rt;
    id_uses_rt   = s.uses_rt;
    ex_memread   = s.memread;
    branch_taken = s.br;
    mem_busy     = s.busy;
    halt_req     = s.halt;
    resume       = s.res;
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    drive_now(s);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drive_now(IDLE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    logic [8:0] e;
    drive_now({5'd5, 5'd5, 5'd5, 6'b110110});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #3;
      exp_q.push_back(9'b00000_00_0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, obs, e);
      end
      checks++;
      if (stall_cycles !== 4'd0) begin
        failures++;
        $display("FAIL reset_stall cycle %0d: got %0d expected 0", i, stall_cycles);
      end
    end
    drive_now(IDLE);
    @(negedge clk);
    rst = 1'b1;
    apply(IDLE);
    exp_q.push_back(9'b11000_00_0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_release: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_load_use;
    stim_t st [0:4];
    logic [8:0] ex [0:4];
    logic [8:0] e;
    st = '{{5'd5, 5'd0, 5'd5, 6'b010000}, IDLE,
           {5'd0, 5'd9, 5'd9, 6'b110000}, {5'd0, 5'd9, 5'd9, 6'b110000}, IDLE};
    ex = '{9'b00010_00_0, 9'b11000_01_0, 9'b00010_00_0, 9'b11000_01_0, 9'b11000_00_0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL load_use row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd2) begin
      failures++;
      $display("FAIL load_use_stall: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_no_stall;
    stim_t st [0:2];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b010000}, {5'd3, 5'd7, 5'd7, 6'b010000},
           {5'd5, 5'd0, 5'd5, 6'b000000}};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      exp_q.push_back(9'b11000_00_0);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL no_stall row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd2) begin
      failures++;
      $display("FAIL no_stall_count: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_branch_load_use;
    stim_t st [0:3];
    logic [8:0] ex [0:3];
    logic [8:0] e;
    st = '{{5'd4, 5'd0, 5'd4, 6'b011000}, {5'd0, 5'd0, 5'd0, 6'b001000},
           {5'd0, 5'd0, 5'd0, 6'b001000}, IDLE};
    ex = '{9'b00010_00_0, 9'b11100_01_0, 9'b11100_00_0, 9'b11000_00_0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL branch_load_use row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      failures++;
      $display("FAIL branch_stall: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_mem_wait;
    stim_t st [0:4];
    logic [8:0] ex [0:4];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b001100}, {5'd0, 5'd0, 5'd0, 6'b000100},
           {5'd0, 5'd0, 5'd0, 6'b000110}, IDLE, IDLE};
    ex = '{9'b00001_00_0, 9'b00001_10_0, 9'b00001_10_0, 9'b11000_10_0, 9'b11000_00_0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mem_wait row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd6) begin
      failures++;
      $display("FAIL mem_wait_stall: got %0d expected 6", stall_cycles);
    end
  endtask

  task automatic test_timeout;
    stim_t st [0:6];
    logic [8:0] ex [0:6];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b000100}, {5'd0, 5'd0, 5'd0, 6'b000100},
           {5'd0, 5'd0, 5'd0, 6'b000100}, {5'd0, 5'd0, 5'd0, 6'b000100},
           {5'd0, 5'd0, 5'd0, 6'b000100}, {5'd0, 5'd0, 5'd0, 6'b000001}, IDLE};
    ex = '{9'b00001_00_0, 9'b00001_10_0, 9'b00001_10_0, 9'b00001_10_0,
           9'b00001_10_0, 9'b00001_11_1, 9'b00001_11_1};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL timeout row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd11) begin
      failures++;
      $display("FAIL timeout_stall: got %0d expected 11", stall_cycles);
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(9'b00000_00_0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL timeout_clear: got %b expected %b", obs, e);
    end
    #3;
    rst = 1'b1;
    apply(IDLE);
    exp_q.push_back(9'b11000_00_0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL timeout_after_reset: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_halt;
    stim_t st [0:8];
    logic [8:0] ex [0:8];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b000010}, {5'd0, 5'd0, 5'd0, 6'b000011}, IDLE,
           {5'd0, 5'd0, 5'd0, 6'b000001}, IDLE, {5'd0, 5'd0, 5'd0, 6'b000100},
           {5'd0, 5'd0, 5'd0, 6'b000010}, {5'd0, 5'd0, 5'd0, 6'b000001}, IDLE};
    ex = '{9'b00001_00_0, 9'b00001_11_0, 9'b00001_11_0, 9'b00001_11_0, 9'b11000_00_0,
           9'b00001_00_0, 9'b00001_10_0, 9'b00001_11_0, 9'b11000_00_0};
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL halt row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      failures++;
      $display("FAIL halt_stall: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_back_to_back;
    stim_t st [0:4];
    logic [8:0] ex [0:4];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b000100}, {5'd6, 5'd0, 5'd6, 6'b010000},
           {5'd0, 5'd0, 5'd0, 6'b000100}, IDLE, IDLE};
    ex = '{9'b00001_00_0, 9'b00010_10_0, 9'b00001_01_0, 9'b11000_10_0, 9'b11000_00_0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back row %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (stall_cycles !== 4'd6) begin
      failures++;
      $display("FAIL back_to_back_stall: got %0d expected 6", stall_cycles);
    end
  endtask

  task automatic test_async_reset;
    stim_t st [0:4];
    logic [8:0] ex [0:4];
    logic [8:0] e;
    st = '{{5'd0, 5'd0, 5'd0, 6'b000100}, {5'd0, 5'd0, 5'd0, 6'b000100},
           {5'd0, 5'd0, 5'd0, 6'b000100}, IDLE, IDLE};
    ex = '{9'b00001_00_0, 9'b00001_10_0, 9'b00001_00_0, 9'b11000_10_0, 9'b11000_00_0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL async_reset row %0d: got %b expected %b", i, obs, e);
      end
      if (i == 1) begin
        #1;
        rst = 1'b0;
        exp_q.push_back(9'b00000_00_0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL async_reset_mid_wait: got %b expected %b", obs, e);
        end
        checks++;
        if (stall_cycles !== 4'd0) begin
          failures++;
          $display("FAIL async_reset_stall: got %0d expected 0", stall_cycles);
        end
        drive_now(IDLE);
        #2;
        rst = 1'b1;
      end
    end
    checks++;
    if (stall_cycles !== 4'd1) begin
      failures++;
      $display("FAIL async_reset_after_stall: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_saturation;
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply({5'd2, 5'd0, 5'd2, 6'b010000});
      exp_q.push_back(9'b00010_00_0);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL saturation row %0d: got %b expected %b", i, obs, e);
      end
      apply(IDLE);
    end
    #2;
    checks++;
    if (stall_cycles !== 4'd15) begin
      failures++;
      $display("FAIL saturation_count: got %0d expected 15", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Sequences the PC, the IF/ID latch and the ID/EX latch from four causes: load-use hazards, taken branches resolved in ID, multi-cycle data-memory waits, and external halt requests.
- Sits beside the decode stage and drives the PCWrite/freeze/bubble/flush controls consumed by IF, IF/ID and ID/EX.
- Also keeps a saturating stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
- MAX_MEM_WAIT, 15, maximum consecutive mem_busy cycles tolerated before a timeout halt (range 1..255).
- PERF_W, 16, width of the stall_cycles counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  5  destination rt of the instruction in EX.
- branch_taken  input  1  ID comparator resolved a taken branch (PCSrc).
- mem_busy  input  1  data memory not ready this cycle.
- halt_req  input  1  level request to halt the pipeline.
- resume  input  1  single-cycle pulse to leave HALTED.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID latch enable (0 = freeze).
- ifid_flush  output  1  zero the IF/ID latch at next edge.
- idex_bubble  output  1  force ID/EX control fields to zero.
- exmem_hold  output  1  hold the EX/MEM and MEM/WB latches.
- seq_state  output  2  current state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, HALTED=3.
- mem_timeout  output  1  sticky; set on wait-limit overrun.
- stall_cycles  output  PERF_W  count of cycles with pc_write=0 outside HALTED.

Behaviour:
- Reset (rst=0, asynchronous):
  - seq_state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - While rst=0: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, exmem_hold=0.
  - Reset mid-stall or mid-wait aborts immediately to RUN.
- Control outputs are combinational from state and current inputs, so a stall takes effect in the same cycle. State, wait_cnt and counters update on the rising clk edge.
- load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Default ("normal") outputs: pc_write=1, ifid_write=1, all others 0.
- RUN, evaluated in priority order:
  1. halt_req: pc_write=0, ifid_write=0, exmem_hold=1; next HALTED.
  2. mem_busy: pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0; next MEM_WAIT, wait_cnt=1.
  3. load_use: pc_write=0, ifid_write=0, idex_bubble=1; next LOAD_STALL.
  4. branch_taken: normal outputs plus ifid_flush=1; stay in RUN.
  5. Otherwise: normal outputs; stay in RUN.
- Simultaneous events:
  - load_use with branch_taken: the stall wins and the flush is not issued. The branch is re-resolved next cycle because ID is held.
  - mem_busy with branch_taken: hold wins and the flush is deferred.
- LOAD_STALL (exactly one cycle): same priority as RUN except load_use is ignored. Next RUN, or MEM_WAIT/HALTED per priority.
- MEM_WAIT:
  - mem_busy=1 and wait_cnt<MAX_MEM_WAIT: hold outputs as in RUN step 2; wait_cnt+1.
  - mem_busy=1 and wait_cnt==MAX_MEM_WAIT: hold outputs; mem_timeout<=1; next HALTED.
  - mem_busy=0: evaluate RUN priority steps 1, 3, 4, 5 in this cycle; wait_cnt<=0; next per that evaluation (RUN if none apply).
  - halt_req during MEM_WAIT is deferred until mem_busy drops.
- HALTED:
  - pc_write=0, ifid_write=0, exmem_hold=1, ifid_flush=0, idex_bubble=0.
  - Exit to RUN when resume=1 & halt_req=0 & mem_timeout=0. Otherwise stay; resume is ignored.
  - mem_timeout clears only on reset.
- stall_cycles: +1 each cycle where pc_write=0 and seq_state!=HALTED. It saturates at 2^PERF_W-1 (no wrap).

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 → same cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle seq_state=1 with normal outputs; stall_cycles=1.
- r0 / no-use: ex_rt=0, id_rs=0, ex_memread=1 → no stall. ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch vs load-use: branch_taken=1 and load_use together → no flush, bubble=1. Next cycle (LOAD_STALL, load_use=0) branch_taken=1 → ifid_flush=1, pc_write=1.
- Memory wait: mem_busy high for 3 cycles → exmem_hold=1 for 3 cycles, seq_state=2. The cycle mem_busy drops gives normal outputs; stall_cycles=3.
- Timeout: MAX_MEM_WAIT=4, mem_busy held high → mem_timeout=1 after the 4th wait cycle, seq_state=3. A resume pulse stays HALTED until rst=0 clears it.
- Halt/resume and async reset: halt_req=1 → HALTED. resume with halt_req=1 → stays. halt_req=0 then resume → RUN next edge. Asserting rst mid-MEM_WAIT (between edges) → outputs 0 and seq_state=0 immediately.
